// File: rtl/char_link_tx.sv
// Parallel character-link transmitter: FIFO-buffered bytes framed as setup/strobe/hold/gap.
// Optional CHARTX_NEWLINE_EXPAND_EN: a sent 0x0D is followed by an internally generated 0x0A frame.
module char_link_tx #(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned SETUP_CYC = 4,
    parameter int unsigned PULSE_CYC = 8,
    parameter int unsigned HOLD_CYC  = 4,
    parameter int unsigned GAP_CYC   = 16
) (
    input  logic                     iCLK,
    input  logic                     iRST_n,
    input  logic [7:0]               iData,
    input  logic                     iValid,
    output logic                     oReady,
    input  logic                     iClrOvf,
    output logic [7:0]               oLinkData,
    output logic                     oLinkStrobe,
    output logic [$clog2(DEPTH):0]   oCount,
    output logic                     oBusy,
    output logic                     oOverflow
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_GAP} state_e;

    state_e          state_q, state_d;
    logic [15:0]     cnt_q, cnt_d;
    logic [7:0]      data_q, data_d;
    logic            strobe_q, strobe_d;
    logic [AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            ovf_q, ovf_d;
    logic [7:0]      mem [DEPTH];
    logic            ready, push, pop;
`ifdef CHARTX_NEWLINE_EXPAND_EN
    logic            nl_q, nl_d;
`endif

    assign ready = (count_q < CW'(DEPTH));
    assign push  = iValid && ready;

    always_ff @(posedge iCLK) begin
        if (push) mem[wptr_q] <= iData;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        strobe_d = strobe_q;
        pop      = 1'b0;
`ifdef CHARTX_NEWLINE_EXPAND_EN
        nl_d     = nl_q;
`endif
        case (state_q)
            S_IDLE: begin
`ifdef CHARTX_NEWLINE_EXPAND_EN
                // Pending LF takes the slot a FIFO pop would use, keeping frame spacing identical.
                if (nl_q) begin
                    data_d  = 8'h0A;
                    nl_d    = 1'b0;
                    state_d = S_SETUP;
                    cnt_d   = 16'(SETUP_CYC - 1);
                end else
`endif
                if (count_q != '0) begin
                    pop     = 1'b1;
                    data_d  = mem[rptr_q];
                    state_d = S_SETUP;
                    cnt_d   = 16'(SETUP_CYC - 1);
`ifdef CHARTX_NEWLINE_EXPAND_EN
                    nl_d    = (mem[rptr_q] == 8'h0D);
`endif
                end
            end
            S_SETUP: begin
                if (cnt_q == 16'd0) begin
                    state_d  = S_STROBE;
                    strobe_d = 1'b1;
                    cnt_d    = 16'(PULSE_CYC - 1);
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_STROBE: begin
                if (cnt_q == 16'd0) begin
                    state_d  = S_HOLD;
                    strobe_d = 1'b0;
                    cnt_d    = 16'(HOLD_CYC - 1);
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_HOLD: begin
                if (cnt_q == 16'd0) begin
                    state_d = S_GAP;
                    cnt_d   = 16'(GAP_CYC - 1);
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_GAP: begin
                if (cnt_q == 16'd0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: begin
                state_d  = S_IDLE;
                strobe_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        wptr_d  = push ? wptr_q + AW'(1) : wptr_q;
        rptr_d  = pop  ? rptr_q + AW'(1) : rptr_q;
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        ovf_d = ovf_q;
        if (iValid && !ready) begin
            ovf_d = 1'b1;
        end else if (iClrOvf) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            data_q   <= '0;
            strobe_q <= 1'b0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
`ifdef CHARTX_NEWLINE_EXPAND_EN
            nl_q     <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            strobe_q <= strobe_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
`ifdef CHARTX_NEWLINE_EXPAND_EN
            nl_q     <= nl_d;
`endif
        end
    end

    assign oReady      = ready;
    assign oLinkData   = data_q;
    assign oLinkStrobe = strobe_q;
    assign oCount      = count_q;
    assign oOverflow   = ovf_q;
`ifdef CHARTX_NEWLINE_EXPAND_EN
    assign oBusy       = (count_q != '0) || (state_q != S_IDLE) || nl_q;
`else
    assign oBusy       = (count_q != '0) || (state_q != S_IDLE);
`endif

endmodule

// File: tb/tb_char_link_tx.sv
// Directed bench for char_link_tx with default parameters; cycle numbers are relative to each test's first push.
module tb_char_link_tx;
    logic       iCLK = 1'b0;
    logic       iRST_n = 1'b0;
    logic [7:0] iData = 8'h00;
    logic       iValid = 1'b0;
    logic       iClrOvf = 1'b0;
    logic       oReady;
    logic [7:0] oLinkData;
    logic       oLinkStrobe;
    logic [3:0] oCount;
    logic       oBusy;
    logic       oOverflow;

    char_link_tx #(
        .DEPTH(8), .SETUP_CYC(4), .PULSE_CYC(8), .HOLD_CYC(4), .GAP_CYC(16)
    ) dut (
        .iCLK(iCLK), .iRST_n(iRST_n), .iData(iData), .iValid(iValid), .oReady(oReady),
        .iClrOvf(iClrOvf), .oLinkData(oLinkData), .oLinkStrobe(oLinkStrobe),
        .oCount(oCount), .oBusy(oBusy), .oOverflow(oOverflow)
    );

    always #5 iCLK = ~iCLK;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step;
        @(posedge iCLK);
        #1;
        cyc++;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_data"},   16'(oLinkData),   16'h00);
        chk({tag, "_strobe"}, 16'(oLinkStrobe), 16'h0);
        chk({tag, "_count"},  16'(oCount),      16'h0);
        chk({tag, "_busy"},   16'(oBusy),       16'h0);
        chk({tag, "_ovf"},    16'(oOverflow),   16'h0);
        chk({tag, "_ready"},  16'(oReady),      16'h1);
    endtask

    initial begin
        int nstr, nxt, r0, r1;
        logic prev;
        logic [7:0] d0, d1;

        // Reset state
        #23;
        chk_reset_vals("rst");
        #4 iRST_n = 1'b1;
        step;

        // Single byte 0x41
        cyc = 0;
        iData = 8'h41; iValid = 1'b1;
        step;
        iValid = 1'b0;
        chk("s_count1", 16'(oCount), 16'd1);
        chk("s_data1", 16'(oLinkData), 16'h00);
        while (cyc <= 40) begin
            chk("s_strobe", 16'(oLinkStrobe), 16'((cyc >= 6 && cyc <= 13) ? 1 : 0));
            chk("s_busy", 16'(oBusy), 16'((cyc < 34) ? 1 : 0));
            if (cyc >= 2) chk("s_data", 16'(oLinkData), 16'h41);
            if (cyc == 2) chk("s_count2", 16'(oCount), 16'd0);
            step;
        end

        // Back-to-back 0x48, 0x49
        cyc = 0; nstr = 0; prev = 1'b0;
        iData = 8'h48; iValid = 1'b1;
        step;
        iData = 8'h49;
        step;
        iValid = 1'b0;
        while (cyc <= 70) begin
            chk("b_strobe", 16'(oLinkStrobe),
                16'(((cyc >= 6 && cyc <= 13) || (cyc >= 39 && cyc <= 46)) ? 1 : 0));
            if (cyc <= 34) chk("b_data0", 16'(oLinkData), 16'h48);
            else           chk("b_data1", 16'(oLinkData), 16'h49);
            chk("b_busy", 16'(oBusy), 16'((cyc < 67) ? 1 : 0));
            if (oLinkStrobe && !prev) nstr++;
            prev = oLinkStrobe;
            step;
        end
        chk("b_pulses", 16'(nstr), 16'd2);

        // Overflow, clear, set-wins, full with simultaneous pop
        cyc = 0;
        while (cyc <= 9) begin
            iValid = 1'b1; iData = 8'(8'h60 + cyc);
            if (cyc == 9) begin
                chk("o_count9", 16'(oCount), 16'd8);
                chk("o_ready9", 16'(oReady), 16'd0);
                chk("o_ovf9", 16'(oOverflow), 16'd0);
            end
            step;
        end
        iValid = 1'b0;
        chk("o_ovf_set", 16'(oOverflow), 16'd1);
        chk("o_count10", 16'(oCount), 16'd8);
        iClrOvf = 1'b1;
        step;
        iClrOvf = 1'b0;
        chk("o_ovf_clr", 16'(oOverflow), 16'd0);
        iValid = 1'b1; iClrOvf = 1'b1;
        step;
        iValid = 1'b0; iClrOvf = 1'b0;
        chk("o_set_wins", 16'(oOverflow), 16'd1);
        chk("o_count12", 16'(oCount), 16'd8);
        iClrOvf = 1'b1;
        step;
        iClrOvf = 1'b0;
        chk("o_ovf_clr2", 16'(oOverflow), 16'd0);
        while (cyc < 34) step;
        chk("o_count34", 16'(oCount), 16'd8);
        iValid = 1'b1; iData = 8'hEE;
        step;
        iValid = 1'b0;
        chk("o_full_pop_count", 16'(oCount), 16'd7);
        chk("o_full_pop_ovf", 16'(oOverflow), 16'd1);
        chk("o_data2", 16'(oLinkData), 16'h61);
        #2 iRST_n = 1'b0;
        #1 chk_reset_vals("o_rst");
        #2 iRST_n = 1'b1;
        step;

        // Reset mid-STROBE
        cyc = 0;
        iData = 8'h41; iValid = 1'b1;
        step;
        iData = 8'h42;
        step;
        iValid = 1'b0;
        while (cyc < 8) step;
        chk("r_pre_strobe", 16'(oLinkStrobe), 16'd1);
        chk("r_pre_count", 16'(oCount), 16'd1);
        #2 iRST_n = 1'b0;
        #1 chk_reset_vals("r_async");
        #2 iRST_n = 1'b1;
        step;
        nstr = 0;
        repeat (80) begin
            if (oLinkStrobe) nstr++;
            step;
        end
        chk("r_no_strobe", 16'(nstr), 16'd0);
        chk("r_busy", 16'(oBusy), 16'd0);

        // Pointer wrap: 20 bytes through an 8-entry FIFO
        cyc = 0; nxt = 0; nstr = 0; prev = 1'b0;
        while (nstr < 20 && cyc < 800) begin
            if (oLinkStrobe && !prev) begin
                chk("w_data", 16'(oLinkData), 16'(nstr));
                nstr++;
            end
            prev = oLinkStrobe;
            if (nxt < 20 && oReady) begin
                iValid = 1'b1; iData = 8'(nxt); nxt++;
            end else begin
                iValid = 1'b0;
            end
            step;
        end
        iValid = 1'b0;
        chk("w_strobes", 16'(nstr), 16'd20);
        chk("w_count", 16'(oCount), 16'd0);
        repeat (40) step;
        chk("w_busy", 16'(oBusy), 16'd0);
        chk("w_ovf", 16'(oOverflow), 16'd0);

        // Carriage return
        cyc = 0; nstr = 0; prev = 1'b0; r0 = -1; r1 = -1; d0 = 8'h00; d1 = 8'h00;
        iData = 8'h0D; iValid = 1'b1;
        step;
        iValid = 1'b0;
        while (cyc <= 75) begin
            if (oLinkStrobe && !prev) begin
                if (nstr == 0) begin r0 = cyc; d0 = oLinkData; end
                if (nstr == 1) begin r1 = cyc; d1 = oLinkData; end
                nstr++;
            end
            prev = oLinkStrobe;
            if (cyc == 35) chk("n_count", 16'(oCount), 16'd0);
`ifdef CHARTX_NEWLINE_EXPAND_EN
            chk("n_busy", 16'(oBusy), 16'((cyc < 67) ? 1 : 0));
`else
            chk("n_busy", 16'(oBusy), 16'((cyc < 34) ? 1 : 0));
`endif
            step;
        end
        chk("n_r0", 16'(r0), 16'd6);
        chk("n_d0", 16'(d0), 16'h0D);
`ifdef CHARTX_NEWLINE_EXPAND_EN
        chk("n_pulses", 16'(nstr), 16'd2);
        chk("n_r1", 16'(r1), 16'd39);
        chk("n_d1", 16'(d1), 16'h0A);
`else
        chk("n_pulses", 16'(nstr), 16'd1);
        chk("n_data_end", 16'(oLinkData), 16'h0D);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
